// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU decoder codes consumed by the ALU and
// the multiply unit, and the multiply-unit state encoding.
package mips_pkg;

  localparam logic [4:0] ALU_MULT  = 5'b10011;  // signed multiply
  localparam logic [4:0] ALU_MULTU = 5'b10101;  // unsigned multiply

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } muldiv_state_t;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add magnitude multiplier datapath.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   load             - capture a_mag/b_mag, clear accumulator and counter
//   a_mag, b_mag     - unsigned multiplicand / multiplier
//   prod_mag         - current {acc, mplier} product (2*WIDTH bits)
//   last             - high during the final iteration step
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] prod_mag,
  output logic               last
);

  localparam int unsigned CNTW = $clog2(WIDTH);

  // {carry, acc, mplier}; carry catches the adder overflow before the shift
  logic [2*WIDTH:0] p_q, p_d;
  logic [WIDTH-1:0] mcand_q;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend = p_q[0] ? mcand_q : '0;
    sum    = {p_q[2*WIDTH], p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    p_d    = {1'b0, sum, p_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      p_q     <= {1'b0, {WIDTH{1'b0}}, b_mag};
      mcand_q <= a_mag;
      cnt_q   <= '0;
    end else begin
      p_q   <= p_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign prod_mag = p_q[2*WIDTH-1:0];
  assign last     = (cnt_q == CNTW'(WIDTH-1));

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply unit with architectural HI/LO registers.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, alucontrol   - request; only mult/multu codes start a multiply
//   srca, srcb          - operands (srca is also mthi/mtlo write data)
//   mthi, mtlo          - move srca into HI / LO (IDLE only, multiply wins)
//   busy                - state is not IDLE
//   done                - one-cycle pulse, HI/LO hold the new product
//   hi, lo              - HI/LO registers
module muldiv_hilo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t state_q, state_d;
  logic              neg_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              is_signed, is_mul, load, last;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag, result;

  assign is_signed = (alucontrol == ALU_MULT);
  assign is_mul    = is_signed || (alucontrol == ALU_MULTU);

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign a_mag = (is_signed && srca[WIDTH-1]) ? -srca : srca;
  assign b_mag = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

  mul_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .prod_mag (prod_mag),
    .last     (last)
  );

  assign result = neg_q ? -prod_mag : prod_mag;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && is_mul) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN:     if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (load) begin
        neg_q <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      end
      if (state_q == FIX) begin
        hi_q   <= result[2*WIDTH-1:WIDTH];
        lo_q   <= result[WIDTH-1:0];
        done_q <= 1'b1;
      end else if (state_q == IDLE && !load) begin
        if (mthi) hi_q <= srca;
        if (mtlo) lo_q <= srca;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo.
module tb_muldiv_hilo;

  localparam logic [4:0] OP_MULT  = 5'b10011;
  localparam logic [4:0] OP_MULTU = 5'b10101;
  localparam logic [4:0] OP_ADD   = 5'b00010;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [4:0]  alucontrol;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Raise start during the cycle before an edge; drop it just after that edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; alucontrol = OP_ADD;
  endtask

  // Sample each cycle at the falling edge until done; returns busy cycle count.
  task automatic wait_done(input string tag, output int busy_n);
    bit ok = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin ok = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic run_mul(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int bn;
    @(negedge clk);
    issue(op, a, b);
    wait_done(tag, bn);
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    int bn, pulses;
    logic [63:0] saved;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    alucontrol = OP_ADD; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // Signed basic with busy window length
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done("s_basic", bn);
    chk("s_basic_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("s_basic_busy33", 64'(bn), 64'd33);
    chk("s_basic_busy_low_at_done", 64'(busy), 64'd0);

    // Mid-RUN reset discards the multiply and clears HI/LO
    @(negedge clk);
    issue(OP_MULTU, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_mid_no_done", 64'(pulses), 64'd0);
    run_mul("after_rst", OP_MULT, 32'd3, 32'd4, 64'd12);

    // Signed corners and mixed signs
    run_mul("s_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_mul("s_min_one", OP_MULT, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    run_mul("s_negneg", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15);
    run_mul("s_negpos", OP_MULT, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    run_mul("u_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Back-to-back: start accepted in the done cycle, old HI/LO held meanwhile
    start = 1'b1; alucontrol = OP_MULTU; srca = 32'd1000; srcb = 32'd1000;
    @(posedge clk); #1 start = 1'b0; alucontrol = OP_ADD;
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    wait_done("b2b", bn);
    chk("b2b_hilo", {hi, lo}, 64'd1000000);

    // Non-multiply start is ignored
    saved = {hi, lo};
    @(negedge clk);
    issue(OP_ADD, 32'd9, 32'd9);
    @(negedge clk);
    chk("add_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("add_hilo", {hi, lo}, saved);

    // Re-start during RUN is ignored
    @(negedge clk);
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1 issue(OP_MULTU, 32'd100, 32'd100);
    wait_done("restart", bn);
    chk("restart_hilo", {hi, lo}, 64'd42);

    // Moves in IDLE
    @(negedge clk);
    mthi = 1'b1; srca = 32'h0000_1234;
    @(posedge clk); #1 mthi = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'd42);
    chk("mthi_no_done", 64'(done), 64'd0);
    mtlo = 1'b1; mthi = 1'b1; srca = 32'hABCD_0001;
    @(posedge clk); #1 mtlo = 1'b0; mthi = 1'b0;
    @(negedge clk);
    chk("mt_both", {hi, lo}, 64'hABCD_0001_ABCD_0001);

    // mtlo coincident with a multiply start: the multiply wins
    @(negedge clk);
    mtlo = 1'b1;
    issue(OP_MULT, 32'd5, 32'd3);
    mtlo = 1'b0;
    @(negedge clk);
    chk("prio_busy", 64'(busy), 64'd1);
    chk("prio_lo_not_written", 64'(lo), 64'hABCD_0001);
    wait_done("prio", bn);
    chk("prio_hilo", {hi, lo}, 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
